// File: rtl/data_mem_resp_pkg.sv
// Shared definitions for the data memory responder: MMIO map, STATUS bit
// positions, write-request payload and byte-merge helpers.
package data_mem_resp_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned BE_W   = DATA_W / 8;

    localparam logic [15:0] MMIO_HI_DEFAULT = 16'hFFFF;

    localparam logic [15:0] OFF_LED     = 16'h0000;
    localparam logic [15:0] OFF_COUNT   = 16'h0004;
    localparam logic [15:0] OFF_COMPARE = 16'h0008;
    localparam logic [15:0] OFF_STATUS  = 16'h000C;

    localparam int unsigned STATUS_PEND_BIT = 0;
    localparam int unsigned STATUS_EN_BIT   = 1;

    localparam logic [DATA_W-1:0] COMPARE_RST = 32'hFFFF_FFFF;

    typedef enum logic [2:0] {
        MMIO_NONE,
        MMIO_LED,
        MMIO_COUNT,
        MMIO_COMPARE,
        MMIO_STATUS
    } mmio_reg_e;

    typedef struct packed {
        logic [BE_W-1:0]   be;
        logic [DATA_W-1:0] data;
    } wr_req_t;

    // Replace the byte lanes selected by be with the matching lanes of new_w.
    function automatic logic [DATA_W-1:0] merge_bytes(
        input logic [DATA_W-1:0] old_w,
        input logic [DATA_W-1:0] new_w,
        input logic [BE_W-1:0]   be
    );
        logic [DATA_W-1:0] res;
        res = old_w;
        for (int i = 0; i < int'(BE_W); i++) begin
            if (be[i]) begin
                res[8*i +: 8] = new_w[8*i +: 8];
            end
        end
        return res;
    endfunction

    // Map a word offset (byte offset bits [15:2]) inside the MMIO window.
    function automatic mmio_reg_e decode_offset(input logic [13:0] word_off);
        mmio_reg_e sel;
        sel = MMIO_NONE;
        if (word_off == OFF_LED[15:2]) begin
            sel = MMIO_LED;
        end else if (word_off == OFF_COUNT[15:2]) begin
            sel = MMIO_COUNT;
        end else if (word_off == OFF_COMPARE[15:2]) begin
            sel = MMIO_COMPARE;
        end else if (word_off == OFF_STATUS[15:2]) begin
            sel = MMIO_STATUS;
        end
        return sel;
    endfunction

endpackage

// File: rtl/dmem_timer.sv
// Free-running timer: COUNT, COMPARE, STATUS (PEND/EN) and the registered
// level interrupt timer_int = PEND & EN.
module dmem_timer
    import data_mem_resp_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  mmio_reg_e         wr_sel_i,
    input  wr_req_t           wr_req_i,
    output logic [DATA_W-1:0] count_o,
    output logic [DATA_W-1:0] compare_o,
    output logic              pend_o,
    output logic              en_o,
    output logic              timer_int_o
);

    logic [DATA_W-1:0] count_q,   count_d;
    logic [DATA_W-1:0] compare_q, compare_d;
    logic              pend_q,    pend_d;
    logic              en_q,      en_d;
    logic              int_q,     int_d;
    logic              pend_set_c;
    logic              pend_clr_c;

    // Next-state: increment or CPU override of COUNT, COMPARE/STATUS writes,
    // match detection on the pre-increment COUNT with set beating clear.
    always_comb begin
        count_d    = count_q + DATA_W'(1);
        compare_d  = compare_q;
        en_d       = en_q;
        pend_clr_c = 1'b0;
        pend_set_c = en_q && (count_q == compare_q);

        if (wr_sel_i == MMIO_COUNT && |wr_req_i.be) begin
            count_d = merge_bytes(count_q, wr_req_i.data, wr_req_i.be);
        end
        if (wr_sel_i == MMIO_COMPARE && |wr_req_i.be) begin
            compare_d = merge_bytes(compare_q, wr_req_i.data, wr_req_i.be);
        end
        if (wr_sel_i == MMIO_STATUS && wr_req_i.be[0]) begin
            en_d       = wr_req_i.data[STATUS_EN_BIT];
            pend_clr_c = wr_req_i.data[STATUS_PEND_BIT];
        end

        pend_d = pend_set_c | (pend_q & ~pend_clr_c);
        int_d  = pend_d & en_d;
    end

    // Timer state registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_q   <= '0;
            compare_q <= COMPARE_RST;
            pend_q    <= 1'b0;
            en_q      <= 1'b0;
            int_q     <= 1'b0;
        end else begin
            count_q   <= count_d;
            compare_q <= compare_d;
            pend_q    <= pend_d;
            en_q      <= en_d;
            int_q     <= int_d;
        end
    end

    assign count_o     = count_q;
    assign compare_o   = compare_q;
    assign pend_o      = pend_q;
    assign en_o        = en_q;
    assign timer_int_o = int_q;

endmodule

// File: rtl/data_mem_resp.sv
// CPU data-port responder: word RAM with byte enables, MMIO decode for the
// LED register and timer, and a registered read-data return path.
module data_mem_resp
    import data_mem_resp_pkg::*;
#(
    parameter int unsigned RAM_AW  = 10,
    parameter logic [15:0] MMIO_HI = MMIO_HI_DEFAULT
) (
    input  logic              cpu_clk_50M,
    input  logic              cpu_rst,
    input  logic [31:0]       daddr,
    input  logic              dce,
    input  logic [3:0]        we,
    input  logic [31:0]       din,
    output logic [31:0]       dm,
    output logic              timer_int,
    output logic [15:0]       led
);

    localparam int unsigned RAM_WORDS = 1 << RAM_AW;

    logic [DATA_W-1:0] mem_q [RAM_WORDS];

    logic [DATA_W-1:0] dm_q,  dm_d;
    logic [15:0]       led_q, led_d;

    logic              is_mmio_c;
    logic              is_read_c;
    logic              is_write_c;
    logic              ram_we_c;
    logic [RAM_AW-1:0] ram_idx_c;
    mmio_reg_e         mmio_sel_c;
    mmio_reg_e         tmr_sel_c;
    wr_req_t           tmr_req_c;
    logic [DATA_W-1:0] rdata_c;
    logic [1:0]        unused_addr_c;

    logic [DATA_W-1:0] tmr_count;
    logic [DATA_W-1:0] tmr_compare;
    logic              tmr_pend;
    logic              tmr_en;

    // Byte offset within a word never affects an access.
    assign unused_addr_c = daddr[1:0];

    // Address decode, write steering, LED update and read-data mux.
    always_comb begin
        is_mmio_c  = (daddr[31:16] == MMIO_HI);
        ram_idx_c  = daddr[RAM_AW+1:2];
        mmio_sel_c = is_mmio_c ? decode_offset(daddr[15:2]) : MMIO_NONE;
        is_read_c  = dce && (we == 4'b0000);
        is_write_c = dce && (we != 4'b0000);
        ram_we_c   = is_write_c && !is_mmio_c && !cpu_rst;

        tmr_sel_c    = is_write_c ? mmio_sel_c : MMIO_NONE;
        tmr_req_c.be = is_write_c ? we : 4'b0000;
        tmr_req_c.data = din;

        led_d = led_q;
        if (is_write_c && mmio_sel_c == MMIO_LED) begin
            if (we[0]) led_d[7:0]  = din[7:0];
            if (we[1]) led_d[15:8] = din[15:8];
        end

        rdata_c = '0;
        if (is_mmio_c) begin
            case (mmio_sel_c)
                MMIO_LED:     rdata_c = {16'h0000, led_q};
                MMIO_COUNT:   rdata_c = tmr_count;
                MMIO_COMPARE: rdata_c = tmr_compare;
                MMIO_STATUS:  rdata_c = {30'b0, tmr_en, tmr_pend};
                default:      rdata_c = '0;
            endcase
        end else begin
            rdata_c = mem_q[ram_idx_c];
        end

        dm_d = is_read_c ? rdata_c : dm_q;
    end

    // RAM array: per-lane writes, no reset, suppressed while in reset.
    always_ff @(posedge cpu_clk_50M) begin
        if (ram_we_c) begin
            for (int i = 0; i < int'(BE_W); i++) begin
                if (we[i]) begin
                    mem_q[ram_idx_c][8*i +: 8] <= din[8*i +: 8];
                end
            end
        end
    end

    // Read-data and LED registers.
    always_ff @(posedge cpu_clk_50M or posedge cpu_rst) begin
        if (cpu_rst) begin
            dm_q  <= '0;
            led_q <= '0;
        end else begin
            dm_q  <= dm_d;
            led_q <= led_d;
        end
    end

    dmem_timer u_timer (
        .clk_i       (cpu_clk_50M),
        .rst_i       (cpu_rst),
        .wr_sel_i    (tmr_sel_c),
        .wr_req_i    (tmr_req_c),
        .count_o     (tmr_count),
        .compare_o   (tmr_compare),
        .pend_o      (tmr_pend),
        .en_o        (tmr_en),
        .timer_int_o (timer_int)
    );

    assign dm  = dm_q;
    assign led = led_q;

endmodule

// File: tb/tb_data_mem_resp.sv
// Self-checking bench for data_mem_resp: directed scenarios plus random
// traffic compared against a cycle-level behavioural model.
module tb_data_mem_resp;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] daddr = '0;
    logic        dce = 1'b0;
    logic [3:0]  we = '0;
    logic [31:0] din = '0;
    logic [31:0] dm;
    logic        timer_int;
    logic [15:0] led;

    int checks = 0;
    int errors = 0;

    // Behavioural model state.
    logic [31:0] m_mem [1024];
    logic [31:0] m_dm, m_count, m_cmp;
    logic [15:0] m_led;
    logic        m_pend, m_en, m_tint;

    data_mem_resp dut (
        .cpu_clk_50M (clk),
        .cpu_rst     (rst),
        .daddr       (daddr),
        .dce         (dce),
        .we          (we),
        .din         (din),
        .dm          (dm),
        .timer_int   (timer_int),
        .led         (led)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_dm = 0; m_led = 0; m_count = 0; m_cmp = 32'hFFFF_FFFF;
        m_pend = 0; m_en = 0; m_tint = 0;
    endtask

    // One clock edge of the specified behaviour, from pre-edge state.
    task automatic model_step(input logic [31:0] a, input logic ce,
                              input logic [3:0] w, input logic [31:0] d);
        logic        mmio, rd, wr, pset, clr;
        logic [15:0] off;
        logic [9:0]  idx;
        logic [31:0] rv, nc, ncmp, t;
        logic        nen;
        mmio = (a[31:16] == 16'hFFFF);
        off  = {a[15:2], 2'b00};
        idx  = a[11:2];
        rd   = ce && (w == 0);
        wr   = ce && (w != 0);
        rv   = 0;
        if (mmio) begin
            if (off == 16'h0)      rv = {16'h0, m_led};
            else if (off == 16'h4) rv = m_count;
            else if (off == 16'h8) rv = m_cmp;
            else if (off == 16'hC) rv = {30'b0, m_en, m_pend};
        end else begin
            rv = m_mem[idx];
        end
        pset = m_en && (m_count == m_cmp);
        nc = m_count + 1;
        ncmp = m_cmp;
        nen = m_en;
        clr = 0;
        if (wr && mmio) begin
            t = (off == 16'h4) ? m_count : (off == 16'h8) ? m_cmp : {16'h0, m_led};
            for (int i = 0; i < 4; i++) if (w[i]) t[8*i +: 8] = d[8*i +: 8];
            if (off == 16'h0) m_led = t[15:0];
            if (off == 16'h4) nc = t;
            if (off == 16'h8) ncmp = t;
            if (off == 16'hC && w[0]) begin
                nen = d[1];
                clr = d[0];
            end
        end
        if (wr && !mmio) begin
            t = m_mem[idx];
            for (int i = 0; i < 4; i++) if (w[i]) t[8*i +: 8] = d[8*i +: 8];
            m_mem[idx] = t;
        end
        if (rd) m_dm = rv;
        m_count = nc;
        m_cmp   = ncmp;
        m_pend  = pset | (m_pend & ~clr);
        m_en    = nen;
        m_tint  = m_pend & m_en;
    endtask

    // Apply one access for one cycle, advance the model, compare outputs.
    task automatic tick(input logic [31:0] a, input logic ce,
                        input logic [3:0] w, input logic [31:0] d);
        daddr = a; dce = ce; we = w; din = d;
        @(posedge clk);
        model_step(a, ce, w, d);
        #1;
        chk("dm", dm, m_dm);
        chk("led", {16'h0, led}, {16'h0, m_led});
        chk("timer_int", {31'h0, timer_int}, {31'h0, m_tint});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(32'h0, 1'b0, 4'h0, 32'h0);
    endtask

    initial begin
        logic [31:0] a, d;
        logic [3:0]  w;
        logic        ce;
        logic [15:0] off;
        int          r;

        model_reset();
        #12;
        chk("rst_dm", dm, 32'h0);
        chk("rst_led", {16'h0, led}, 32'h0);
        chk("rst_int", {31'h0, timer_int}, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        // COUNT starts at 0 and increments on the first edge after reset.
        tick(32'hFFFF_0004, 1'b1, 4'h0, 32'h0);
        chk("count_first", dm, 32'h0);
        tick(32'hFFFF_0004, 1'b1, 4'h0, 32'h0);
        chk("count_second", dm, 32'h1);
        tick(32'hFFFF_0008, 1'b1, 4'h0, 32'h0);
        chk("compare_rst", dm, 32'hFFFF_FFFF);

        // Give every RAM word a known value.
        for (int i = 0; i < 1024; i++) tick(32'(i) << 2, 1'b1, 4'hF, $urandom);

        // Full write, read back, partial write, alias read.
        tick(32'h0000_0010, 1'b1, 4'hF, 32'hDEAD_BEEF);
        tick(32'h0000_0010, 1'b1, 4'h0, 32'h0);
        chk("ram_full", dm, 32'hDEAD_BEEF);
        tick(32'h0000_0010, 1'b1, 4'b0101, 32'h1122_3344);
        chk("dm_hold_on_write", dm, 32'hDEAD_BEEF);
        tick(32'h0000_0010, 1'b1, 4'h0, 32'h0);
        chk("ram_partial", dm, 32'hDE22_BE44);
        tick(32'h0000_1013, 1'b1, 4'h0, 32'h0);
        chk("ram_alias", dm, 32'hDE22_BE44);
        tick(32'h0000_0014, 1'b0, 4'h0, 32'h0);
        chk("dm_hold_idle", dm, 32'hDE22_BE44);

        // Timer: COMPARE=5, COUNT=0, EN; PEND sets the edge COUNT==5 is seen.
        tick(32'hFFFF_0008, 1'b1, 4'hF, 32'd5);
        tick(32'hFFFF_0004, 1'b1, 4'hF, 32'd0);
        tick(32'hFFFF_000C, 1'b1, 4'hF, 32'd2);
        idle(4);
        chk("int_before_match", {31'h0, timer_int}, 32'h0);
        idle(1);
        chk("int_on_match", {31'h0, timer_int}, 32'h1);

        // Clear in the same cycle as a new match: set wins; later clear works.
        tick(32'hFFFF_0004, 1'b1, 4'hF, 32'd5);
        tick(32'hFFFF_000C, 1'b1, 4'hF, 32'd3);
        chk("set_beats_clear", {31'h0, timer_int}, 32'h1);
        tick(32'hFFFF_000C, 1'b1, 4'hF, 32'd3);
        chk("w1c_clears", {31'h0, timer_int}, 32'h0);
        tick(32'hFFFF_000C, 1'b1, 4'h0, 32'h0);
        chk("status_read", dm, 32'h2);
        tick(32'hFFFF_0040, 1'b1, 4'h0, 32'h0);
        chk("unmapped_read", dm, 32'h0);

        // Reset in the middle of a burst; the colliding RAM write is dropped.
        tick(32'hFFFF_0000, 1'b1, 4'hF, 32'h0000_A5A5);
        tick(32'hFFFF_000C, 1'b1, 4'h1, 32'h2);
        tick(32'h0000_0040, 1'b1, 4'h0, 32'h0);
        daddr = 32'h0000_0040; dce = 1'b1; we = 4'hF; din = 32'h1234_5678;
        rst = 1'b1;
        #1;
        chk("async_rst_led", {16'h0, led}, 32'h0);
        chk("async_rst_dm", dm, 32'h0);
        chk("async_rst_int", {31'h0, timer_int}, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        chk("rst_led_held", {16'h0, led}, 32'h0);
        tick(32'hFFFF_0008, 1'b1, 4'h0, 32'h0);
        chk("rst_compare", dm, 32'hFFFF_FFFF);
        tick(32'hFFFF_0004, 1'b1, 4'h0, 32'h0);
        chk("rst_count", dm, 32'h1);
        tick(32'h0000_0040, 1'b1, 4'h0, 32'h0);
        tick(32'hFFFF_000C, 1'b1, 4'h0, 32'h0);
        chk("rst_status", dm, 32'h0);

        // Random traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            r  = $urandom_range(0, 9);
            ce = ($urandom_range(0, 7) != 0);
            d  = $urandom;
            case ($urandom_range(0, 3))
                0, 3:    w = 4'h0;
                1:       w = 4'hF;
                default: w = 4'($urandom);
            endcase
            if (r < 5) begin
                a = $urandom;
                a[31:16] = 16'($urandom_range(0, 16'hFFFE));
            end else begin
                case ($urandom_range(0, 6))
                    0: off = 16'h0000;
                    1: off = 16'h0004;
                    2: off = 16'h0008;
                    3: off = 16'h000C;
                    4: off = 16'h0010;
                    5: off = 16'($urandom);
                    default: off = 16'h0008;
                endcase
                a = {16'hFFFF, off[15:2], 2'($urandom)};
                if (off == 16'h0008) d = m_count + 32'($urandom_range(1, 6));
                if (off == 16'h000C && $urandom_range(0, 1) == 1) w = 4'h1;
            end
            tick(a, ce, w, d);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
